// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master register window and engine.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_STOP
    } i2c_state_e;

    // Control word bit positions
    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_STOP    = 1;
    localparam int unsigned CTRL_READ    = 2;
    localparam int unsigned CTRL_NACK_TX = 3;
    localparam int unsigned CTRL_GO      = 8;

    // Status word bit positions
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_NACK = 2;
    localparam int unsigned STAT_HELD = 3;

    // Register word addresses of the window
    localparam logic [7:0] ADDR_TXDATA = 8'd60;
    localparam logic [7:0] ADDR_CTRL   = 8'd61;
    localparam logic [7:0] ADDR_STATUS = 8'd62;
    localparam logic [7:0] ADDR_RXDATA = 8'd63;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period sequencer: CLK_DIV clocks per quarter, four quarters per step.
// Optional I2C_CLK_STRETCH_EN holds Q1 while a slave keeps SCL low.
module i2c_quarter_timer #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       scl_i,
    output logic [1:0] quarter,
    output logic       q_last,
    output logic       step_done
);

    localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [1:0]    quarter_q;
    logic          advance;

`ifdef I2C_CLK_STRETCH_EN
    // Counting in Q1 only begins once SCL is actually seen high
    assign advance = run && !((quarter_q == 2'd1) && !scl_i);
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign advance    = run;
`endif

    assign quarter   = quarter_q;
    assign q_last    = advance && (cnt_q == LAST);
    assign step_done = q_last && (quarter_q == 2'd3);

    // Quarter and in-quarter counters; cleared whenever the engine is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            quarter_q <= '0;
        end else if (!run) begin
            cnt_q     <= '0;
            quarter_q <= '0;
        end else if (advance) begin
            if (cnt_q == LAST) begin
                cnt_q     <= '0;
                quarter_q <= quarter_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: START / 8-bit transfer / ACK / STOP on open-drain SCL/SDA.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching in Q1.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_data,
    input  logic        we_ctrl,
    input  logic [31:0] wdata,
    output logic [31:0] status,
    output logic [7:0]  rx_data,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    input  logic        scl_i
);

    i2c_state_e state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d, rxsh_q, rxsh_d, rx_q, rx_d;
    logic       stop_q, stop_d, read_q, read_d, nacktx_q, nacktx_d;
    logic       busy_q, busy_d, done_q, done_d, nack_q, nack_d, held_q, held_d;
    logic       scl_q, scl_d, sda_q, sda_d;
    logic [1:0] quarter, q_nxt;
    logic       q_last, step_done;
    logic       unused_wdata;

    assign unused_wdata = ^wdata[31:9];

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (state_q != ST_IDLE),
        .scl_i     (scl_i),
        .quarter   (quarter),
        .q_last    (q_last),
        .step_done (step_done)
    );

    // State and datapath registers, including registered bus drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            tx_q     <= '0;
            rxsh_q   <= '0;
            rx_q     <= '0;
            stop_q   <= 1'b0;
            read_q   <= 1'b0;
            nacktx_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            held_q   <= 1'b0;
            scl_q    <= 1'b0;
            sda_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rxsh_q   <= rxsh_d;
            rx_q     <= rx_d;
            stop_q   <= stop_d;
            read_q   <= read_d;
            nacktx_q <= nacktx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
            held_q   <= held_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
        end
    end

    // Next-state logic; bus levels are derived from the upcoming state/quarter
    // so the registered outputs change on the first clock of each quarter
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rxsh_d   = rxsh_q;
        rx_d     = rx_q;
        stop_d   = stop_q;
        read_d   = read_q;
        nacktx_d = nacktx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        nack_d   = nack_q;
        held_d   = held_q;
        scl_d    = scl_q;
        sda_d    = sda_q;

        q_nxt = quarter;
        if (step_done) begin
            q_nxt = 2'd0;
        end else if (q_last) begin
            q_nxt = quarter + 2'd1;
        end

        if (we_data && !busy_q) begin
            tx_d = wdata[7:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (we_ctrl && wdata[CTRL_GO]) begin
                    stop_d   = wdata[CTRL_STOP];
                    read_d   = wdata[CTRL_READ];
                    nacktx_d = wdata[CTRL_NACK_TX];
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    nack_d   = 1'b0;
                    bit_d    = 3'd7;
                    state_d  = wdata[CTRL_START] ? ST_START : ST_DATA;
                end
            end
            ST_START: begin
                if (step_done) begin
                    held_d  = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (q_last && (quarter == 2'd1)) begin
                    rxsh_d = {rxsh_q[6:0], sda_i};
                end
                if (step_done) begin
                    if (bit_q == 3'd0) begin
                        state_d = ST_ACK;
                        if (read_q) begin
                            rx_d = rxsh_d;
                        end
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (q_last && (quarter == 2'd1) && !read_q) begin
                    nack_d = sda_i;
                end
                if (step_done) begin
                    if (stop_q) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (step_done) begin
                    held_d  = 1'b0;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE: begin
                scl_d = held_d;
                if (!held_d) begin
                    sda_d = 1'b0;
                end
            end
            ST_START: begin
                scl_d = (q_nxt == 2'd0) || (q_nxt == 2'd3);
                sda_d = (q_nxt >= 2'd2);
            end
            ST_DATA: begin
                scl_d = (q_nxt == 2'd0) || (q_nxt == 2'd3);
                sda_d = read_d ? 1'b0 : ~tx_d[bit_d];
            end
            ST_ACK: begin
                scl_d = (q_nxt == 2'd0) || (q_nxt == 2'd3);
                sda_d = read_d ? ~nacktx_d : 1'b0;
            end
            ST_STOP: begin
                scl_d = (q_nxt == 2'd0);
                sda_d = (q_nxt <= 2'd1);
            end
            default: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
        endcase
    end

    // Status word and read-back values
    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy_q;
        status[STAT_DONE] = done_q;
        status[STAT_NACK] = nack_q;
        status[STAT_HELD] = held_q;
    end

    assign rx_data = rx_q;
    assign scl_oe  = scl_q;
    assign sda_oe  = sda_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl with a bus-level slave/observer model.
module tb_i2c_master_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_data = 1'b0;
    logic        we_ctrl = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] status;
    logic [7:0]  rx_data;
    logic        scl_oe, sda_oe;
    logic        sda_line, scl_line, slave_pull;

    logic        stretch = 1'b0;
    logic        ack_en = 1'b0;
    logic        rd_active = 1'b0;
    logic [7:0]  rd_byte = 8'h00;
    int          bit_cnt = 9;
    int          next_idx = 0;
    logic [7:0]  obs_bits = '0;
    logic [7:0]  obs_byte = '0;
    logic        obs_ack = 1'b0;
    int          n_starts = 0;
    int          n_stops = 0;

    int          cyc = 0;
    int          go_cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          done_seen = 0;
    logic        done_prev = 1'b0;

    typedef struct {
        logic [31:0] status;
        logic [7:0]  rx;
        int          lat;
        logic [7:0]  byte_v;
        logic        ack;
        int          starts;
        int          stops;
        logic        scl;
    } exp_t;

    exp_t exp_q[$];

    i2c_master_ctrl #(.CLK_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .we_data (we_data),
        .we_ctrl (we_ctrl),
        .wdata   (wdata),
        .status  (status),
        .rx_data (rx_data),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe),
        .sda_i   (sda_line),
        .scl_i   (scl_line)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Open-drain bus with pull-ups
    assign scl_line = ~scl_oe & ~stretch;
    assign sda_line = ~sda_oe & ~slave_pull;
    assign slave_pull = (rd_active && next_idx < 8) ? ~rd_byte[7 - next_idx]
                                                    : (ack_en && next_idx == 8);

    always @(posedge scl_line) begin
        if (bit_cnt == 9) bit_cnt = 0;
        if (bit_cnt < 8) begin
            obs_bits[7 - bit_cnt] = sda_line;
        end else begin
            obs_ack   = sda_line;
            obs_byte  = obs_bits;
            rd_active = 1'b0;
        end
        bit_cnt++;
    end

    always @(negedge scl_line) next_idx = (bit_cnt == 9) ? 0 : bit_cnt;

    always @(negedge sda_line) if (scl_line === 1'b1) begin bit_cnt = 0; n_starts++; end
    always @(posedge sda_line) if (scl_line === 1'b1) begin bit_cnt = 9; n_stops++; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each DONE rising edge is one completed command
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (status[1] && !done_prev) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_done: got completion at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("status", status, e.status);
                    chk("rx_data", {24'b0, rx_data}, {24'b0, e.rx});
                    chk("latency", cyc - go_cyc, e.lat);
                    chk("bus_byte", {24'b0, obs_byte}, {24'b0, e.byte_v});
                    chk("bus_ack", {31'b0, obs_ack}, {31'b0, e.ack});
                    chk("starts", n_starts, e.starts);
                    chk("stops", n_stops, e.stops);
                    chk("scl_idle", {31'b0, scl_oe}, {31'b0, e.scl});
                end
            end
            done_prev = status[1];
        end
    end

    task automatic expect_cmd(input logic [31:0] st, input logic [7:0] rx, input int lat,
                              input logic [7:0] b, input logic a, input int s, input int p,
                              input logic scl);
        exp_t e;
        e.status = st; e.rx = rx; e.lat = lat; e.byte_v = b; e.ack = a;
        e.starts = s; e.stops = p; e.scl = scl;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] d, input logic [8:0] c);
        @(negedge clk);
        we_data = 1'b1;
        wdata   = {24'b0, d};
        @(negedge clk);
        we_data  = 1'b0;
        we_ctrl  = 1'b1;
        wdata    = {23'b0, c};
        go_cyc   = cyc;
        n_starts = 0;
        n_stops  = 0;
        @(negedge clk);
        we_ctrl = 1'b0;
        wdata   = '0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int k;
        n0 = done_seen;
        k = 0;
        while (done_seen == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_seen == n0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL timeout: got no completion in %0d cycles expected DONE", budget);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", {31'b0, scl_oe}, 32'd0);
        chk("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
        chk("rst_status", status, 32'd0);
        chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
        rst = 1'b0;

        // Reset mid-byte aborts to the released bus
        ack_en = 1'b1;
        issue(8'h55, 9'h103);
        wait_until(go_cyc + 40);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_scl_oe", {31'b0, scl_oe}, 32'd0);
        chk("abort_sda_oe", {31'b0, sda_oe}, 32'd0);
        chk("abort_status", status, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write 0xA5 with START+STOP, slave ACKs
        expect_cmd(32'h2, 8'h00, 177, 8'hA5, 1'b0, 1, 1, 1'b0);
        issue(8'hA5, 9'h103);
        wait_done(400);

        // Write 0x3C with START only, slave NACKs; bus stays held
        ack_en = 1'b0;
        expect_cmd(32'hE, 8'h00, 161, 8'h3C, 1'b1, 1, 0, 1'b1);
        issue(8'h3C, 9'h101);
        wait_done(400);

        // Read 0x5A with master NACK and STOP
        rd_byte   = 8'h5A;
        rd_active = 1'b1;
        expect_cmd(32'h2, 8'h5A, 161, 8'h5A, 1'b1, 0, 1, 1'b0);
        issue(8'h00, 9'h10E);
        wait_done(400);
        rd_active = 1'b0;

        // Writes while busy are ignored
        ack_en = 1'b1;
        expect_cmd(32'h2, 8'h5A, 177, 8'h11, 1'b0, 1, 1, 1'b0);
        issue(8'h11, 9'h103);
        chk("busy_after_go", {31'b0, status[0]}, 32'd1);
        wait_until(go_cyc + 40);
        we_data = 1'b1;
        wdata   = 32'hFF;
        @(negedge clk);
        we_data = 1'b0;
        we_ctrl = 1'b1;
        wdata   = 32'h103;
        @(negedge clk);
        we_ctrl = 1'b0;
        wdata   = '0;
        wait_done(400);
        repeat (200) @(negedge clk);

`ifdef I2C_CLK_STRETCH_EN
        // Slave stretches Q1 of bit 3 by 20 cycles
        expect_cmd(32'h2, 8'h5A, 197, 8'h96, 1'b0, 1, 1, 1'b0);
        issue(8'h96, 9'h103);
        wait_until(go_cyc + 84);
        stretch = 1'b1;
        wait_until(go_cyc + 105);
        stretch = 1'b0;
        wait_done(400);
`endif

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Byte-level I2C master engine behind the memory-mapped I2C register window at words 60–63 (TX data, control, status, RX data). It turns CPU register writes into START / 8-bit transfer / ACK / STOP sequences on open-drain SCL/SDA. It reports progress through the status word, which the CPU polls. It consumes the TX-data and control write strobes produced by the address decoder and supplies the status and RX-data read values.

## Interface
- `CLK_DIV`, default 125: `clk` cycles per SCL quarter-period. Minimum 2. With a 50 MHz clock this gives 100 kHz.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we_data`  in  1  TX data register write strobe (word 60).
- `we_ctrl`  in  1  control register write strobe (word 61).
- `wdata`  in  32  CPU write data. `[7:0]` is used for TX data. `[8:0]` is used for control.
- `status`  out  32  status word (word 62). `[0]` BUSY, `[1]` DONE, `[2]` NACK, `[3]` HELD. Other bits read 0.
- `rx_data`  out  8  last received byte (word 63).
- `scl_oe`  out  1  1 pulls SCL low, 0 releases it.
- `sda_oe`  out  1  1 pulls SDA low, 0 releases it.
- `sda_i`  in  1  SDA pad input, already synchronised.
- `scl_i`  in  1  SCL pad input, already synchronised. Used only when clock stretching is compiled in.

## Operation
- Control bits:
  - `[0]` START: send START before the byte.
  - `[1]` STOP: send STOP after the ACK slot.
  - `[2]` READ: receive a byte instead of transmitting.
  - `[3]` NACK_TX: on a read, the master sends NACK instead of ACK.
  - `[8]` GO: launch the command. GO is self-clearing and never stored.
- TX data register: loaded on `we_data` only while BUSY=0. Writes while BUSY=1 are ignored.
- GO while BUSY=0:
  - latch the control bits;
  - set BUSY, clear DONE and NACK;
  - enter START if START=1, otherwise DATA.
- GO while BUSY=1 is ignored.
- A command with START=0 while HELD=0 is still executed as issued. Software is responsible for legal framing.
- FSM states: IDLE → START → DATA (bits 7..0, MSB first) → ACK → STOP (if STOP=1) → IDLE.
- Each state step lasts four quarters Q0..Q3, each `CLK_DIV` clocks long.
- DATA and ACK bit, per quarter:
  - Q0: SCL low; set SDA to the bit value (1 = released).
  - Q1 and Q2: SCL released.
  - Last clock of Q1: sample `sda_i`.
  - Q3: SCL low.
- ACK slot:
  - On a write, SDA is released and the sampled value goes to NACK (1 = NACK).
  - On a read, the master drives `NACK_TX`.
- Read data: shifted in from `sda_i` samples. `rx_data` is updated once, at the end of bit 0.
- START quarters:
  - Q0: SDA released, SCL low.
  - Q1: SCL released.
  - Q2: SDA low.
  - Q3: SCL low.
- The same START sequence serves as a repeated START while the bus is HELD.
- STOP quarters:
  - Q0: SDA low, SCL low.
  - Q1: SCL released.
  - Q2: SDA released.
  - Q3: hold.
- HELD: set at the end of START, cleared at the end of STOP.
- While idle and HELD=1, SCL stays low and SDA keeps the last ACK-slot level.
- Completion, on returning to IDLE: BUSY←0 and DONE←1. DONE stays 1 until the next accepted GO.

## Timing
- Reset values:
  - `scl_oe`=0 and `sda_oe`=0 (bus released);
  - `status`=0 and `rx_data`=0;
  - FSM in IDLE, all counters 0.
- Reset asserted mid-transfer aborts immediately to the reset values. No STOP is generated.
- BUSY is 1 in the cycle after the GO write.
- Total command length, with Q = `CLK_DIV`, counted from the GO write to DONE=1:
  - START + byte + STOP: 44·Q + 1 cycles.
  - Byte only: 36·Q + 1 cycles.
- `we_data` and `we_ctrl` in the same cycle: the data write is applied first, so GO uses the new byte.
- Bus outputs are registered and change on the first clock of each quarter.

## Configuration
- `I2C_CLK_STRETCH_EN`, when defined:
  - the quarter counter holds in Q1 until `scl_i`=1, so a slave can stretch the clock;
  - the Q1 count starts once SCL is seen high.
- Without the macro: `scl_i` is unused and timing is purely counter-based, as above.

## Structure
- Package `i2c_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, ACK, STOP);
  - control-bit indices and status-bit indices;
  - the register word addresses 60–63.
- Sub-module `i2c_quarter_timer` provides the quarter counter:
  - inputs: `clk`, `rst`, `run`, `scl_i`;
  - outputs: a 2-bit quarter index, `q_last` (last clock of a quarter), and `step_done` (end of Q3);
  - contains the stretch logic.

## Test plan
All scenarios use `CLK_DIV`=4.
- Reset mid-byte: `rst` pulse during DATA → `scl_oe`=0, `sda_oe`=0, `status`=0 on the next edge; a subsequent GO works normally.
- Write with START+STOP: data 0xA5, ctrl 0x103, slave ACKs → SDA shows START then 1,0,1,0,0,1,0,1 → STOP; DONE=1 and NACK=0 at cycle 177; HELD=0 afterwards.
- Write NACK: data 0x3C, ctrl 0x101, slave leaves SDA high in the ACK slot → NACK=1, DONE=1, HELD=1, SCL held low at idle.
- Read: after the previous case, ctrl 0x10E, slave drives 0x5A → `rx_data`=0x5A; master releases SDA in the ACK slot (NACK); STOP issued; HELD=0.
- Busy protection: GO with data 0x11, then during DATA write data 0xFF and ctrl 0x103 → both ignored; 0x11 is transmitted; DONE=1 exactly once.
- Stretch (with `I2C_CLK_STRETCH_EN`): hold `scl_i`=0 for 20 cycles in Q1 of bit 3 → completion is delayed by exactly 20 cycles; data is unchanged.
